// File: rtl/axil_cfg_sequencer_if.sv
// AXI-Lite bus bundle shared by the configuration sequencer and its register-file target.
// No storage; master/slave modports fix signal direction at each end.
interface axil_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axil_cfg_sequencer.sv
// Purpose: AXI-Lite master replaying a parameter table of register writes and masked read-polls.
// Latency: first valid 1 cycle after start; zero-wait write costs AW_W 1 + B 1 + NEXT 1 cycles.
// Backpressure: every valid is held stable until its own handshake; table order never reorders.
module axil_cfg_sequencer #(
    parameter int                                 ADDR_WIDTH   = 32,
    parameter int                                 DATA_WIDTH   = 32,
    parameter int                                 CMD_NUM      = 8,
    parameter logic [CMD_NUM-1:0][ADDR_WIDTH-1:0] CMD_ADDR     = '0,
    parameter logic [CMD_NUM-1:0][DATA_WIDTH-1:0] CMD_DATA     = '0,
    parameter logic [CMD_NUM-1:0][DATA_WIDTH-1:0] CMD_MASK     = '1,
    parameter logic [CMD_NUM-1:0]                 CMD_POLL     = '0,
    parameter int                                 POLL_TIMEOUT = 1024,
    parameter bit                                 AUTO_START   = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       start_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_o,
    output logic [$clog2(CMD_NUM):0]   err_idx_o,
    axil_if.master                     m_axil
);
    localparam int SW = (CMD_NUM > 1) ? $clog2(CMD_NUM) : 1;
    localparam int EW = $clog2(CMD_NUM) + 1;
    localparam int TW = $clog2(POLL_TIMEOUT + 1);
    localparam logic [SW-1:0] LAST_IDX = SW'(CMD_NUM - 1);
    localparam logic [TW-1:0] TO_VAL   = TW'(POLL_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE, S_AW_W, S_B, S_AR, S_R, S_NEXT, S_ERR, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] idx_q, idx_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [EW-1:0] err_idx_q, err_idx_d;
    logic          aw_done_q, aw_done_d;
    logic          w_done_q, w_done_d;
    logic          err_q, err_d;
    logic          auto_q, auto_d;

    logic          awvalid, wvalid, arvalid, bready, rready;
    logic          aw_hs, w_hs, disp, expired, rd_match;
    logic [SW-1:0] disp_idx;

    assign aw_hs    = awvalid & m_axil.awready;
    assign w_hs     = wvalid & m_axil.wready;
    assign expired  = (cnt_q == TO_VAL);
    assign rd_match = ((m_axil.rdata & CMD_MASK[idx_q]) == (CMD_DATA[idx_q] & CMD_MASK[idx_q]));

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        err_idx_d = err_idx_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        err_d     = err_q;
        auto_d    = auto_q;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        arvalid   = 1'b0;
        bready    = 1'b0;
        rready    = 1'b0;
        disp      = 1'b0;
        disp_idx  = '0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i || auto_q) begin
                    auto_d    = 1'b0;
                    err_d     = 1'b0;
                    err_idx_d = '0;
                    disp      = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_AW_W: begin
                awvalid = ~aw_done_q;
                wvalid  = ~w_done_q;
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = S_B;
                end else begin
                    aw_done_d = aw_done_q | aw_hs;
                    w_done_d  = w_done_q | w_hs;
                end
            end
            S_B: begin
                bready = 1'b1;
                if (m_axil.bvalid) state_d = (m_axil.bresp == 2'b00) ? S_NEXT : S_ERR;
            end
            S_AR: begin
                arvalid = 1'b1;
                if (!expired) cnt_d = cnt_q + 1'b1;
                // An expired poll still completes AR and collects its R beat, so no transfer is left open.
                if (m_axil.arready) state_d = S_R;
            end
            S_R: begin
                rready = 1'b1;
                if (!expired) cnt_d = cnt_q + 1'b1;
                if (m_axil.rvalid) begin
                    if (m_axil.rresp != 2'b00) state_d = S_ERR;
                    else if (rd_match)         state_d = S_NEXT;
                    else if (expired)          state_d = S_ERR;
                    else                       state_d = S_AR;
                end
            end
            S_NEXT: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    disp     = 1'b1;
                    disp_idx = idx_q + 1'b1;
                end
            end
            S_ERR: begin
                err_d     = 1'b1;
                err_idx_d = EW'(idx_q);
                state_d   = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        if (disp) begin
            idx_d   = disp_idx;
            cnt_d   = '0;
            state_d = CMD_POLL[disp_idx] ? S_AR : S_AW_W;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            err_idx_q <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_q     <= 1'b0;
            auto_q    <= AUTO_START;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            err_idx_q <= err_idx_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            err_q     <= err_d;
            auto_q    <= auto_d;
        end
    end

    assign busy_o    = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done_o    = (state_q == S_DONE);
    assign err_o     = err_q;
    assign err_idx_o = err_idx_q;

    assign m_axil.awaddr  = CMD_ADDR[idx_q];
    assign m_axil.awprot  = 3'b000;
    assign m_axil.awvalid = awvalid;
    assign m_axil.wdata   = CMD_DATA[idx_q];
    assign m_axil.wstrb   = '1;
    assign m_axil.wvalid  = wvalid;
    assign m_axil.bready  = bready;
    assign m_axil.araddr  = CMD_ADDR[idx_q];
    assign m_axil.arprot  = 3'b000;
    assign m_axil.arvalid = arvalid;
    assign m_axil.rready  = rready;
endmodule

// File: tb/tb_axil_cfg_sequencer.sv
// Directed bench: table of 3 writes, a poll on 0xC, and a final write, against a behavioural AXI-Lite slave.
module tb_axil_cfg_sequencer;
    localparam logic [4:0][31:0] T_ADDR = {32'h10, 32'h0C, 32'h08, 32'h04, 32'h00};
    localparam logic [4:0][31:0] T_DATA = {32'h55, 32'h01, 32'h33, 32'h22, 32'h11};
    localparam logic [4:0][31:0] T_MASK = {32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    localparam logic [4:0]       T_POLL = 5'b01000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, err;
    logic [3:0] err_idx;

    axil_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axil_cfg_sequencer #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .CMD_NUM(5),
        .CMD_ADDR(T_ADDR), .CMD_DATA(T_DATA), .CMD_MASK(T_MASK), .CMD_POLL(T_POLL),
        .POLL_TIMEOUT(64), .AUTO_START(1'b1)
    ) dut (
        .clk_i(clk), .rstn_i(rst_n), .start_i(start),
        .busy_o(busy), .done_o(done), .err_o(err), .err_idx_o(err_idx),
        .m_axil(bus)
    );

    always #5 clk = ~clk;

    // slave knobs, driven only by the stimulus process
    bit          rnd = 1'b0;
    bit          err_en = 1'b0;
    logic [31:0] err_addr = 32'h0;
    logic [31:0] poll_val = 32'h0;

    // slave state and bookkeeping
    logic [31:0] regs [0:7];
    logic [31:0] log_addr [0:127];
    logic [31:0] log_data [0:127];
    int          wr_n = 0, aw_beats = 0, w_beats = 0, rd_poll = 0, done_cnt = 0;
    logic [31:0] aw_addr, w_data, ar_addr;
    logic        aw_got, w_got, ar_got;
    int          aw_wait, w_wait, b_wait, ar_wait, r_wait;

    function automatic int dly();
        return rnd ? int'($urandom_range(0, 5)) : 0;
    endfunction

    always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.awready <= 1'b0; bus.wready <= 1'b0; bus.bvalid <= 1'b0; bus.bresp <= 2'b00;
            bus.arready <= 1'b0; bus.rvalid <= 1'b0; bus.rdata <= 32'h0; bus.rresp <= 2'b00;
            aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
            aw_wait <= 0; w_wait <= 0; b_wait <= 0; ar_wait <= 0; r_wait <= 0;
            aw_addr <= 32'h0; w_data <= 32'h0; ar_addr <= 32'h0;
        end else begin
            if (bus.bvalid && bus.bready) begin
                bus.bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
            end else if (aw_got && w_got && !bus.bvalid) begin
                if (b_wait == 0) begin
                    bus.bvalid <= 1'b1;
                    b_wait     <= dly();
                    if (err_en && aw_addr == err_addr) begin
                        bus.bresp <= 2'b10;
                    end else begin
                        bus.bresp           <= 2'b00;
                        regs[aw_addr[4:2]]  <= w_data;
                        log_addr[wr_n]      <= aw_addr;
                        log_data[wr_n]      <= w_data;
                        wr_n                <= wr_n + 1;
                    end
                end else b_wait <= b_wait - 1;
            end
            if (bus.awvalid && bus.awready) begin
                bus.awready <= 1'b0; aw_got <= 1'b1; aw_addr <= bus.awaddr;
                aw_beats <= aw_beats + 1; aw_wait <= dly();
            end else if (!aw_got && !bus.awready) begin
                if (aw_wait == 0) bus.awready <= 1'b1; else aw_wait <= aw_wait - 1;
            end
            if (bus.wvalid && bus.wready) begin
                bus.wready <= 1'b0; w_got <= 1'b1; w_data <= bus.wdata;
                w_beats <= w_beats + 1; w_wait <= dly();
            end else if (!w_got && !bus.wready) begin
                if (w_wait == 0) bus.wready <= 1'b1; else w_wait <= w_wait - 1;
            end
            if (bus.arvalid && bus.arready) begin
                bus.arready <= 1'b0; ar_got <= 1'b1; ar_addr <= bus.araddr; ar_wait <= dly();
                if (bus.araddr == 32'hC) rd_poll <= rd_poll + 1;
            end else if (!ar_got && !bus.arready) begin
                if (ar_wait == 0) bus.arready <= 1'b1; else ar_wait <= ar_wait - 1;
            end
            if (bus.rvalid && bus.rready) begin
                bus.rvalid <= 1'b0; ar_got <= 1'b0;
            end else if (ar_got && !bus.rvalid) begin
                if (r_wait == 0) begin
                    bus.rvalid <= 1'b1;
                    bus.rresp  <= 2'b00;
                    bus.rdata  <= (ar_addr == 32'hC) ? poll_val : regs[ar_addr[4:2]];
                    r_wait     <= dly();
                end else r_wait <= r_wait - 1;
            end
        end
    end

    int n_vec = 0, n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        bit seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check({tag, "_done"}, 32'(seen), 32'd1);
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    endtask

    // pulse start; on the falling edge after the sampling edge the run must already be issuing
    task automatic kick(input string tag, input logic exp_aw);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_err_clr"}, {28'h0, err, err_idx}, 32'h0);
        check({tag, "_first_valid"}, {30'h0, bus.awvalid, bus.wvalid}, exp_aw ? 32'h3 : 32'h0);
    endtask

    logic [31:0] exp_a [0:3] = '{32'h00, 32'h04, 32'h08, 32'h10};
    logic [31:0] exp_d [0:3] = '{32'h11, 32'h22, 32'h33, 32'h55};

    task automatic chk_writes(input string tag, input int base, input int n);
        check({tag, "_wr_count"}, 32'(wr_n - base), 32'(n));
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s_wr%0d_addr", tag, k), log_addr[base + k], exp_a[k]);
            check($sformatf("%s_wr%0d_data", tag, k), log_data[base + k], exp_d[k]);
        end
    endtask

    initial begin
        int wb, rb, db, ab, wbb;
        bit hit;

        repeat (3) @(negedge clk);
        check("rst_ctrl", {28'h0, busy, done, err, 1'b0}, 32'h0);
        check("rst_err_idx", 32'(err_idx), 32'h0);
        check("rst_valids", {27'h0, bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}, 32'h0);
        check("const_wstrb_prot", {22'h0, bus.wstrb, bus.awprot, bus.arprot}, 32'h3C0);

        // auto-start run: poll target flips to 1 after several reads
        wb = wr_n; rb = rd_poll; db = done_cnt;
        rst_n = 1'b1;
        @(negedge clk);
        check("auto_first_valid", {29'h0, busy, bus.awvalid, bus.wvalid}, 32'h7);
        check("auto_awaddr", bus.awaddr, 32'h0);
        hit = 1'b0;
        for (int i = 0; i < 500 && !hit; i++) begin
            @(negedge clk);
            if (rd_poll - rb >= 5) hit = 1'b1;
        end
        check("auto_poll_reads", 32'(hit), 32'd1);
        poll_val = 32'h1;
        wait_done("auto", 500);
        repeat (5) @(negedge clk);
        check("auto_done_once", 32'(done_cnt - db), 32'd1);
        check("auto_err", {28'h0, err, err_idx}, 32'h0);
        chk_writes("auto", wb, 4);
        check("reg0", regs[0], 32'h11);
        check("reg1", regs[1], 32'h22);
        check("reg2", regs[2], 32'h33);

        // poll never satisfied: timeout on entry 3, entry 4 skipped, a start while busy is dropped
        poll_val = 32'h2;
        wb = wr_n; rb = rd_poll; db = done_cnt;
        kick("tmo", 1'b1);
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_done("tmo", 2000);
        check("tmo_err", 32'(err), 32'd1);
        check("tmo_err_idx", 32'(err_idx), 32'd3);
        check("tmo_multi_read", 32'(rd_poll - rb >= 10), 32'd1);
        chk_writes("tmo", wb, 3);
        repeat (10) @(negedge clk);
        check("tmo_done_once", 32'(done_cnt - db), 32'd1);
        check("tmo_idle", 32'(busy), 32'd0);

        // SLVERR on entry 1 aborts; a fresh start clears the error and reruns everything
        poll_val = 32'h1; err_en = 1'b1; err_addr = 32'h4;
        wb = wr_n;
        kick("slverr", 1'b1);
        wait_done("slverr", 500);
        check("slverr_err", 32'(err), 32'd1);
        check("slverr_err_idx", 32'(err_idx), 32'd1);
        chk_writes("slverr", wb, 1);
        err_en = 1'b0;
        wb = wr_n;
        kick("rerun", 1'b1);
        wait_done("rerun", 500);
        check("rerun_err", {28'h0, err, err_idx}, 32'h0);
        chk_writes("rerun", wb, 4);

        // random ready/valid delays on every channel
        rnd = 1'b1;
        for (int r = 0; r < 3; r++) begin
            wb = wr_n; ab = aw_beats; wbb = w_beats;
            kick($sformatf("rnd%0d", r), 1'b1);
            wait_done($sformatf("rnd%0d", r), 3000);
            check($sformatf("rnd%0d_err", r), {28'h0, err, err_idx}, 32'h0);
            check($sformatf("rnd%0d_aw_beats", r), 32'(aw_beats - ab), 32'd4);
            check($sformatf("rnd%0d_w_beats", r), 32'(w_beats - wbb), 32'd4);
            chk_writes($sformatf("rnd%0d", r), wb, 4);
        end

        // reset in the middle of entry 1's write; auto-start reruns cleanly afterwards
        kick("mid", 1'b1);
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            if (bus.awvalid && bus.awaddr == 32'h4) hit = 1'b1;
        end
        check("mid_reach_aw", 32'(hit), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valids", {28'h0, bus.awvalid, bus.wvalid, bus.arvalid, busy}, 32'h0);
        rnd = 1'b0;
        @(negedge clk);
        wb = wr_n;
        rst_n = 1'b1;
        wait_done("mid_rerun", 500);
        check("mid_rerun_err", {28'h0, err, err_idx}, 32'h0);
        chk_writes("mid_rerun", wb, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
